// File: rtl/mc_pi_pkg.sv
// Shared types and helpers for the Monte-Carlo pi engine: FSM state encoding,
// default LFSR constants and a width-generic Galois LFSR step.
package mc_pi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_X = 2'd1,
    SQ_Y = 2'd2,
    ACC  = 2'd3
  } mc_state_e;

  localparam int          LFSR_MAX_W    = 32;
  localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED      = 16'hACE1;

  // Narrower LFSRs pass zero-extended state and taps; the right shift keeps upper bits zero.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] cur,
                                                      input logic [LFSR_MAX_W-1:0] taps);
    lfsr_next = (cur >> 1) ^ (cur[0] ? taps : {LFSR_MAX_W{1'b0}});
  endfunction

endpackage

// File: rtl/mc_pi_engine_if.sv
// Control/status bundle of mc_pi_engine. MC_PI_SAMPLE_LIMIT_EN adds sample_limit.
interface mc_pi_engine_if #(
  parameter int CNT_W  = 16,
  parameter int LFSR_W = 16
);
  logic              run;
  logic              clear;
  logic              seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic [CNT_W-1:0]  cnt_total;
  logic [CNT_W-1:0]  cnt_in;
  logic              busy;
  logic              done;
`ifdef MC_PI_SAMPLE_LIMIT_EN
  logic [CNT_W-1:0]  sample_limit;

  modport master (output run, clear, seed_load, seed_in, sample_limit,
                  input  cnt_total, cnt_in, busy, done);
  modport slave  (input  run, clear, seed_load, seed_in, sample_limit,
                  output cnt_total, cnt_in, busy, done);
`else
  modport master (output run, clear, seed_load, seed_in,
                  input  cnt_total, cnt_in, busy, done);
  modport slave  (input  run, clear, seed_load, seed_in,
                  output cnt_total, cnt_in, busy, done);
`endif
endinterface

// File: rtl/mc_pi_seq_square.sv
// Bit-serial shift-add squarer: bit 0 on the start edge, one bit per enabled edge after,
// exact product with valid after FRAC_W enabled edges; everything holds while en=0.
module mc_pi_seq_square #(
  parameter int FRAC_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                en,
  input  logic [FRAC_W-1:0]   a,
  output logic [2*FRAC_W-1:0] p,
  output logic                valid
);
  localparam int PW = 2 * FRAC_W;
  localparam int SW = $clog2(FRAC_W);

  logic [PW-1:0]     acc_r;
  logic [PW-1:0]     mcand_r;
  logic [FRAC_W-1:0] mplier_r;
  logic [SW-1:0]     step_r;
  logic              active_r;
  logic              valid_r;

  // Partial-product accumulation, one multiplier bit per enabled cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      step_r   <= '0;
      active_r <= 1'b0;
      valid_r  <= 1'b0;
    end else if (en && start) begin
      acc_r    <= a[0] ? PW'(a) : '0;
      mcand_r  <= PW'(a) << 1;
      mplier_r <= a >> 1;
      step_r   <= SW'(1);
      active_r <= 1'b1;
      valid_r  <= 1'b0;
    end else if (en && active_r) begin
      acc_r    <= acc_r + (mplier_r[0] ? mcand_r : '0);
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      step_r   <= step_r + SW'(1);
      if (step_r == SW'(FRAC_W - 1)) begin
        active_r <= 1'b0;
        valid_r  <= 1'b1;
      end
    end
  end

  assign p     = acc_r;
  assign valid = valid_r;

endmodule

// File: rtl/mc_pi_engine.sv
// Monte-Carlo pi estimator: LFSR-drawn x,y, bit-serial squaring, total/inside counters.
// Build option MC_PI_SAMPLE_LIMIT_EN stops sampling when cnt_total reaches bus.sample_limit.
module mc_pi_engine
  import mc_pi_pkg::*;
#(
  parameter int                FRAC_W    = 8,
  parameter int                CNT_W     = 16,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEF_LFSR_TAPS),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEF_SEED)
) (
  input logic           clk,
  input logic           rst_n,
  mc_pi_engine_if.slave bus
);
  localparam int             PW       = 2 * FRAC_W;
  localparam int             BW       = $clog2(FRAC_W);
  localparam logic [PW:0]    UNIT_SUM = {1'b1, {PW{1'b0}}};

  mc_state_e         state_r;
  logic [BW-1:0]     bit_cnt_r;
  logic [FRAC_W-1:0] operand_r;
  logic [PW-1:0]     xsq_r;
  logic [LFSR_W-1:0] lfsr_r;
  logic [CNT_W-1:0]  cnt_total_r;
  logic [CNT_W-1:0]  cnt_in_r;
  logic              busy_r;
  logic              done_r;

  logic              adv_s;
  logic              last_bit_s;
  logic              sq_en_s;
  logic              sq_start_s;
  logic [PW-1:0]     sq_p_s;
  logic              sq_valid_s;
  logic [PW:0]       sum_s;
  logic              inside_s;
  logic [CNT_W-1:0]  tot_inc_s;
  logic              sat_s;
  logic              lim_hit_s;
  logic [LFSR_W-1:0] lfsr_nxt_s;

  // Advance qualifiers, squarer control and accumulate-stage decisions
  always_comb begin
    adv_s      = bus.run & ~bus.clear & ~bus.seed_load;
    last_bit_s = (bit_cnt_r == BW'(FRAC_W - 1));
    if (adv_s && (state_r == SQ_X || state_r == SQ_Y)) begin
      sq_en_s    = 1'b1;
      sq_start_s = (bit_cnt_r == '0);
    end else begin
      sq_en_s    = 1'b0;
      sq_start_s = 1'b0;
    end
    sum_s      = {1'b0, xsq_r} + {1'b0, sq_p_s};
    inside_s   = (sum_s < UNIT_SUM);
    tot_inc_s  = cnt_total_r + CNT_W'(1);
    sat_s      = &tot_inc_s;
`ifdef MC_PI_SAMPLE_LIMIT_EN
    lim_hit_s  = (bus.sample_limit != '0) && (tot_inc_s == bus.sample_limit);
`else
    lim_hit_s  = 1'b0;
`endif
    lfsr_nxt_s = LFSR_W'(lfsr_next(LFSR_MAX_W'(lfsr_r), LFSR_MAX_W'(LFSR_TAPS)));
  end

  mc_pi_seq_square #(.FRAC_W(FRAC_W)) u_square (
    .clk   (clk),
    .rst_n (rst_n),
    .start (sq_start_s),
    .en    (sq_en_s),
    .a     (operand_r),
    .p     (sq_p_s),
    .valid (sq_valid_s)
  );

  // Random source; a zero seed would lock the LFSR, so it falls back to SEED
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_r <= SEED;
    end else if (bus.seed_load) begin
      lfsr_r <= (bus.seed_in == '0) ? SEED : bus.seed_in;
    end else if (bus.clear) begin
      lfsr_r <= lfsr_r;
    end else if (bus.run) begin
      lfsr_r <= lfsr_nxt_s;
    end
  end

  // Sample sequencer and counters; x^2 is parked in xsq_r while y is squared
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      state_r     <= IDLE;
      bit_cnt_r   <= '0;
      cnt_total_r <= '0;
      cnt_in_r    <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      if (!rst_n) begin
        operand_r <= '0;
        xsq_r     <= '0;
      end
    end else if (adv_s) begin
      case (state_r)
        IDLE: begin
          if (!done_r) begin
            state_r   <= SQ_X;
            operand_r <= lfsr_r[FRAC_W-1:0];
            bit_cnt_r <= '0;
            busy_r    <= 1'b1;
          end
        end
        SQ_X: begin
          if (last_bit_s) begin
            state_r   <= SQ_Y;
            operand_r <= lfsr_r[FRAC_W-1:0];
            bit_cnt_r <= '0;
          end else begin
            bit_cnt_r <= bit_cnt_r + BW'(1);
          end
        end
        SQ_Y: begin
          if (bit_cnt_r == '0 && sq_valid_s) begin
            xsq_r <= sq_p_s;
          end
          if (last_bit_s) begin
            state_r   <= ACC;
            bit_cnt_r <= '0;
          end else begin
            bit_cnt_r <= bit_cnt_r + BW'(1);
          end
        end
        ACC: begin
          cnt_total_r <= tot_inc_s;
          if (inside_s) begin
            cnt_in_r <= cnt_in_r + CNT_W'(1);
          end
          if (sat_s || lim_hit_s) begin
            state_r <= IDLE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            state_r   <= SQ_X;
            operand_r <= lfsr_r[FRAC_W-1:0];
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cnt_total = cnt_total_r;
  assign bus.cnt_in    = cnt_in_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: doc/mc_pi_engine.md
Name: mc_pi_engine

Overview:
- Parametrised Monte-Carlo pi estimator, the successor to the fixed 8-bit unit.
- Draws random fixed-point x, y in [0,1) from a seedable LFSR and computes x^2+y^2 with a bit-serial squarer. Counts total samples and samples inside the unit circle.
- Sits behind the tile's io pins. The byte selection for the 8-bit pins is done outside this block.

Parameters:
- FRAC_W, 8: fraction bits of x and y (value = x/2^FRAC_W); legal 4..16.
- CNT_W, 16: width of both sample counters; legal 4..32.
- LFSR_W, 16: LFSR width; must be >= FRAC_W.
- LFSR_TAPS, 16'hB400: Galois feedback mask, width LFSR_W.
- SEED, 16'hACE1: default nonzero LFSR value, width LFSR_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  1 = advance; 0 = freeze FSM, squarer and LFSR.
- clear  in  1  synchronous clear of counters and FSM.
- seed_load  in  1  load LFSR from seed_in.
- seed_in  in  LFSR_W  seed value.
- cnt_total  out  CNT_W  completed samples.
- cnt_in  out  CNT_W  samples with x^2+y^2 < 1.
- busy  out  1  FSM not in IDLE.
- done  out  1  cnt_total saturated, or the sample limit was reached.

Behaviour:
- Reset (rst_n=0 at an edge):
  - FSM=IDLE; cnt_total=0, cnt_in=0, busy=0, done=0; LFSR=SEED.
  - Reset is already decided as synchronous, active-low, on the single clock clk.
- Priority: rst_n > clear > seed_load > run.
  - clear: counters=0, done=0, FSM=IDLE, squarer idle; LFSR unchanged.
  - seed_load: LFSR<=seed_in, or SEED if seed_in==0 (prevents lock-up). FSM and counters hold.
  - clear and seed_load in the same cycle: both take effect.
- LFSR: Galois right shift, one step per cycle while run=1 and no higher-priority event; x and y take LFSR[FRAC_W-1:0].
- FSM states: IDLE, SQ_X, SQ_Y, ACC. All transitions require run=1; with run=0 every register holds.
  - IDLE->SQ_X when done=0: latch x.
  - SQ_X: FRAC_W cycles, one squarer bit per cycle; on the last cycle store x^2 and latch y; ->SQ_Y.
  - SQ_Y: FRAC_W cycles computing y^2; ->ACC.
  - ACC: 1 cycle. sum = x^2 + y^2 at 2*FRAC_W+1 bits. cnt_total+=1; cnt_in+=1 iff sum[2*FRAC_W]==0.
  - After ACC: ->SQ_X and latch a new x, unless done becomes 1, in which case ->IDLE.
- Timing:
  - Sample period = 2*FRAC_W+1 cycles (17 at default).
  - cnt_total=k is first visible after 1+17k run edges from IDLE.
- Saturation: when cnt_total reaches 2^CNT_W-1 in ACC, done=1 and the FSM goes to IDLE. Counters never wrap. done is cleared only by clear or reset.
- run deasserted mid-sample: the partial product is preserved, and resuming completes the sample bit-exact.
- Squarer: shift-add, unsigned FRAC_W x FRAC_W -> 2*FRAC_W bits, exact.

Optional Feature:
- Macro: MC_PI_SAMPLE_LIMIT_EN.
- With it:
  - Extra input sample_limit [CNT_W-1:0].
  - In ACC, if the new cnt_total == sample_limit, done=1 and the FSM goes to IDLE.
  - sample_limit==0 means no limit (saturation only).
- Without it: no extra port; done only on saturation.

Decomposition:
- Shared package mc_pi_pkg holds:
  - FSM state enum (IDLE, SQ_X, SQ_Y, ACC);
  - default LFSR_TAPS and SEED constants;
  - function lfsr_next(width-generic via max width).
- One sub-module, mc_pi_seq_square:
  - ports clk, rst_n, start, en, a[FRAC_W-1:0], p[2*FRAC_W-1:0], valid;
  - result valid FRAC_W cycles after start, holding while en=0.

Test Plan:
- Reset and idle: rst_n=0 for 2 cycles, then run=0 for 10 cycles -> cnt_total=0, cnt_in=0, busy=0, done=0, LFSR==16'hACE1.
- Throughput: defaults, run=1 held for 1+170 edges -> cnt_total=10. cnt_in matches a C model of the same LFSR/threshold; busy=1 throughout.
- Squarer boundary (mc_pi_seq_square, FRAC_W=8):
  - a=0xB5 -> p=32761 after 8 cycles; a=0xB6 -> 33124; a=0xFF -> 65025.
  - Engine with forced x=y=0xB5 -> inside (65522); x=y=0xB6 -> outside (66248).
- Seed handling: seed_load with seed_in=0 -> LFSR=SEED. seed_load with 16'h1234 mid-sample -> LFSR=16'h1234 and FSM state unchanged.
- Pause/clear: deassert run for 5 cycles inside SQ_Y -> final counts equal an uninterrupted run. clear asserted in ACC together with run -> counters=0, FSM=IDLE, busy=0 next cycle.
- Saturation/limit:
  - CNT_W=4 -> after 15 samples done=1, cnt_total=15, counts frozen for 100 more cycles.
  - With MC_PI_SAMPLE_LIMIT_EN and sample_limit=3 -> done=1 at cnt_total=3.
